// File: rtl/gray_window_3x3_if.sv
// Pixel-stream and window bus between RAW2GRAY, the 3x3 window builder and the convolution stage.
// The master drives pixels in and receives windows; the slave is the window builder.
interface gray_window_3x3_if #(
  parameter int DATA_W = 12
);
  logic [DATA_W-1:0]   iDATA;
  logic                iDVAL;
  logic                iSOF;
  logic [9*DATA_W-1:0] oWIN;
  logic [15:0]         oX;
  logic [15:0]         oY;
  logic                oDVAL;

  modport master (
    output iDATA, iDVAL, iSOF,
    input  oWIN, oX, oY, oDVAL
  );

  modport slave (
    input  iDATA, iDVAL, iSOF,
    output oWIN, oX, oY, oDVAL
  );
endinterface

// File: rtl/gray_window_3x3.sv
// 3x3 neighbourhood builder: two line buffers plus a shifting tap window.
// Emits one window per accepted pixel whose centre lies strictly inside the frame.
module gray_window_3x3 #(
  parameter int DATA_W = 12,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480
) (
  input  logic            iCLK,
  input  logic            iRST,
  gray_window_3x3_if.slave bus
);
  localparam int          AW       = $clog2(IMG_W);
  localparam logic [15:0] LAST_COL = 16'(IMG_W - 1);
  localparam logic [15:0] LAST_ROW = 16'(IMG_H - 1);

  logic [15:0]                col_r;
  logic [15:0]                row_r;
  logic [15:0]                pixCol_s;
  logic [15:0]                pixRow_s;
  logic [AW-1:0]              rdAddr_s;
  logic [AW-1:0]              wrAddr_s;

  logic [DATA_W-1:0]          lb0Mem_r [IMG_W];
  logic [DATA_W-1:0]          lb1Mem_r [IMG_W];
  logic [DATA_W-1:0]          lb0Rd_r;
  logic [DATA_W-1:0]          lb1Rd_r;

  logic [DATA_W-1:0]          pix_r;
  logic [15:0]                col1_r;
  logic [15:0]                row1_r;
  logic                       v1_r;

  logic [8:0][DATA_W-1:0]     win_r;
  logic [15:0]                outX_r;
  logic [15:0]                outY_r;
  logic                       outDval_r;

  // Position of the pixel on the bus this cycle; a start-of-frame pixel is always (0,0).
  always_comb begin
    pixCol_s = col_r;
    pixRow_s = row_r;
    if (bus.iSOF) begin
      pixCol_s = 16'd0;
      pixRow_s = 16'd0;
    end else begin
      pixCol_s = col_r;
      pixRow_s = row_r;
    end
  end

  assign rdAddr_s = pixCol_s[AW-1:0];
  assign wrAddr_s = col1_r[AW-1:0];

  // Raster position counters; frames roll over on their own, iSOF re-aligns them.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      col_r <= 16'd0;
      row_r <= 16'd0;
    end else if (bus.iDVAL) begin
      if (pixCol_s == LAST_COL) begin
        col_r <= 16'd0;
        row_r <= (pixRow_s == LAST_ROW) ? 16'd0 : pixRow_s + 16'd1;
      end else begin
        col_r <= pixCol_s + 16'd1;
        row_r <= pixRow_s;
      end
    end else if (bus.iSOF) begin
      col_r <= 16'd0;
      row_r <= 16'd0;
    end else begin
      col_r <= col_r;
      row_r <= row_r;
    end
  end

  // Stage 0 capture of the accepted pixel and its position.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      pix_r  <= {DATA_W{1'b0}};
      col1_r <= 16'd0;
      row1_r <= 16'd0;
      v1_r   <= 1'b0;
    end else begin
      v1_r <= bus.iDVAL;
      if (bus.iDVAL) begin
        pix_r  <= bus.iDATA;
        col1_r <= pixCol_s;
        row1_r <= pixRow_s;
      end else begin
        pix_r  <= pix_r;
        col1_r <= col1_r;
        row1_r <= row1_r;
      end
    end
  end

  // Line buffers: read in stage 0, rotate rows in stage 1 (LB0 -> LB1, new pixel -> LB0).
  always_ff @(posedge iCLK) begin
    if (bus.iDVAL) begin
      lb0Rd_r <= lb0Mem_r[rdAddr_s];
      lb1Rd_r <= lb1Mem_r[rdAddr_s];
    end
    if (v1_r) begin
      lb1Mem_r[wrAddr_s] <= lb0Rd_r;
      lb0Mem_r[wrAddr_s] <= pix_r;
    end
  end

  // Stage 1: shift the window one column left, load the new column, qualify interior centres.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      win_r     <= '0;
      outX_r    <= 16'd0;
      outY_r    <= 16'd0;
      outDval_r <= 1'b0;
    end else if (v1_r) begin
      for (int r = 0; r < 3; r++) begin
        win_r[3*r]     <= win_r[3*r + 1];
        win_r[3*r + 1] <= win_r[3*r + 2];
      end
      win_r[2]  <= lb1Rd_r;
      win_r[5]  <= lb0Rd_r;
      win_r[8]  <= pix_r;
      outX_r    <= col1_r - 16'd1;
      outY_r    <= row1_r - 16'd1;
      // Requiring col >= 2 also guarantees the previous row's columns have been shifted out.
      outDval_r <= (row1_r >= 16'd2) && (col1_r >= 16'd2);
    end else begin
      win_r     <= win_r;
      outX_r    <= outX_r;
      outY_r    <= outY_r;
      outDval_r <= 1'b0;
    end
  end

  assign bus.oWIN  = win_r;
  assign bus.oX    = outX_r;
  assign bus.oY    = outY_r;
  assign bus.oDVAL = outDval_r;
endmodule

// File: doc/gray_window_3x3.md
Name: gray_window_3x3

Overview:
- Sits between RAW2GRAY and the 3x3 convolution stage in imgproc.
- Consumes the 12-bit grayscale pixel stream and buffers the two previous image rows in line buffers.
- Presents a complete 3x3 neighbourhood plus centre coordinates to the convolution block, one window per accepted interior pixel.

Parameters:
- DATA_W, 12: grayscale pixel width.
- IMG_W, 640: pixels per grayscale row; minimum 3.
- IMG_H, 480: rows per grayscale frame; minimum 3.

Ports:
- iCLK  in  1  clock.
- iRST  in  1  asynchronous active-low reset.
- iDATA  in  DATA_W  grayscale pixel.
- iDVAL  in  1  iDATA valid this cycle; may have gaps, no backpressure.
- iSOF  in  1  start-of-frame strobe; synchronous clear of position counters.
- oWIN  out  9*DATA_W  window taps, flattened: oWIN[DATA_W*(3r+c) +: DATA_W] = P[r][c].
  - r=0 is the oldest row, r=2 the current row.
  - c=0 is the oldest column, c=2 the newest column.
- oX  out  16  column of the centre tap P[1][1].
- oY  out  16  row of the centre tap P[1][1].
- oDVAL  out  1  oWIN/oX/oY valid, single-cycle pulse per window.

Behaviour:

Reset (iRST=0, asynchronous):
- oWIN, oX, oY, oDVAL = 0.
- Column counter col, row counter row, window registers and pipeline valid bits = 0.
- Line-buffer RAM contents are not cleared; stale data is never emitted because of the interior rule below.

Position counters:
- Advance only on accepted pixels (iDVAL=1).
- col counts 0..IMG_W-1; at IMG_W-1 it wraps to 0 and row increments.
- row counts 0..IMG_H-1; at IMG_H-1 (with col wrap) it wraps to 0, so frames roll over automatically.
- iSOF=1 forces col=row=0. If iSOF and iDVAL are both high in the same cycle, that pixel is (0,0) and the counters become col=1, row=0.
- iSOF does not flush the pipeline; a window already in flight still emerges.

Line buffers:
- Two IMG_W x DATA_W RAMs: LB0 holds row-1, LB1 holds row-2. Synchronous-read RAM is permitted.
- Stage 0 (cycle of an accepted pixel): issue read of LB0[col] and LB1[col]; register iDATA, col, row and v1 = iDVAL.
- Stage 1 (v1=1):
  - write LB1[col] <= LB0 read data and LB0[col] <= registered iDATA;
  - shift the window left: P[r][0] <= P[r][1], P[r][1] <= P[r][2];
  - load the new column: P[0][2] <= LB1 data, P[1][2] <= LB0 data, P[2][2] <= pixel;
  - register oX = col-1, oY = row-1;
  - oDVAL <= 1 iff row >= 2 and col >= 2; otherwise oDVAL <= 0.
- Read and write addresses of back-to-back pixels differ, so no read-during-write hazard arises.

Latency and throughput:
- oDVAL rises exactly 2 clocks after the iDVAL cycle of the pixel that completes the window.
- Sustains one pixel per clock.
- Input gaps produce matching output gaps; the window holds its contents while iDVAL=0.

Window output:
- Only interior centres are emitted: oX in 1..IMG_W-2, oY in 1..IMG_H-2.
- That gives (IMG_W-2)*(IMG_H-2) windows per frame, in raster order.
- Border centres are never emitted; the convolution stage owns border fill.
- Windows never straddle a row: they are emitted only when col >= 2, so after a row wrap the stale columns are shifted out before the next emit.
- No arithmetic is performed on pixel data; taps are passed bit-exact.

Test Plan:
- Ramp frame: IMG_W=8, IMG_H=6, pixel = 16*y+x, iDVAL held high.
  - First oDVAL comes 2 clocks after input (2,2), with oX=1, oY=1.
  - oWIN taps P00..P22 = 0x00, 0x01, 0x02, 0x10, 0x11, 0x12, 0x20, 0x21, 0x22.
  - Exactly 24 pulses per frame; last window has centre (6,4) and P22=0x57.
- Same ramp with iDVAL toggled in a random 50% pattern: identical sequence of oWIN/oX/oY values; each oDVAL comes 2 clocks after its completing pixel.
- iSOF asserted mid-frame at row 3, col 5, coincident with iDVAL:
  - that pixel is counted as (0,0);
  - no oDVAL until new-frame pixel (2,2);
  - windows then contain only new-frame rows.
- Two frames back-to-back without iSOF: row wraps automatically; second frame produces the same 24 windows; no window mixes frame-1 row 5 into frame-2 rows 0..1.
- iRST pulsed low mid-row: all outputs read 0 asynchronously; after release, no oDVAL until 2 full rows plus 3 pixels have been re-accepted.
- All pixels = 0xFFF: every tap reads 0xFFF, with no width truncation across the 9*DATA_W bus.
